// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer: sequences stack-machine opcodes into push/pop/tos strobes for an external operand stack
// Ports:
//   clk, rst_n                     clock and asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake (ready only while idle)
//   cmd_op, cmd_data               opcode and PUSH immediate
//   stk_push/stk_pop/stk_tos       one-hot strobes to the stack
//   stk_din / stk_dout             data to the stack / registered data from the stack
//   result, result_valid           POP/TOS return value and its one-cycle qualifier
//   error                          one-cycle pulse on a rejected command
//   depth                          locally tracked entry count
module stack_op_sequencer #(
  parameter int DW    = 8,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [DW-1:0]            cmd_data,
  output logic                     stk_push,
  output logic                     stk_pop,
  output logic                     stk_tos,
  output logic [DW-1:0]            stk_din,
  input  logic [DW-1:0]            stk_dout,
  output logic [DW-1:0]            result,
  output logic                     result_valid,
  output logic                     error,
  output logic [$clog2(DEPTH):0]   depth
);
  localparam int DPW = $clog2(DEPTH) + 1;
  localparam logic [2:0] OP_PUSH = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_AND = 3'd3,
                         OP_NOT  = 3'd4, OP_POP = 3'd5, OP_TOS = 3'd6, OP_DUP = 3'd7;
  typedef enum logic [2:0] {IDLE, PSH, RDB, RDA, PEEK, WB, OUT, ERR} state_e;
  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [DW-1:0]   imm_q, imm_d, b_q, b_d, result_q, result_d, alu;
  logic [DPW-1:0]  depth_q, depth_d;
  logic            rv_q, rv_d, need1, need2, grow, ok;
  assign need2 = cmd_op inside {OP_ADD, OP_SUB, OP_AND};
  assign need1 = cmd_op != OP_PUSH;
  assign grow  = cmd_op inside {OP_PUSH, OP_DUP};
  assign ok    = !(need2 && depth_q < DPW'(2)) && !(need1 && depth_q == '0) &&
                 !(grow && depth_q == DPW'(DEPTH));
  // In WB, stk_dout holds the second-from-top (binary ops) or the only operand.
  assign alu = op_q == OP_ADD ? stk_dout + b_q :
               op_q == OP_SUB ? stk_dout - b_q :
               op_q == OP_AND ? stk_dout & b_q :
               op_q == OP_NOT ? ~stk_dout : stk_dout;
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    imm_d    = imm_q;
    b_d      = b_q;
    result_d = result_q;
    depth_d  = depth_q;
    rv_d     = 1'b0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_tos  = 1'b0;
    stk_din  = '0;
    error    = 1'b0;
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        op_d    = cmd_op;
        imm_d   = cmd_data;
        state_d = !ok ? ERR : cmd_op == OP_PUSH ? PSH : (cmd_op inside {OP_TOS, OP_DUP}) ? PEEK : RDB;
      end
      PSH: begin
        stk_push = 1'b1;
        stk_din  = imm_q;
        depth_d  = depth_q + DPW'(1);
        state_d  = IDLE;
      end
      RDB: begin
        stk_pop = 1'b1;
        depth_d = depth_q - DPW'(1);
        state_d = op_q == OP_NOT ? WB : op_q == OP_POP ? OUT : RDA;
      end
      RDA: begin
        stk_pop = 1'b1;
        depth_d = depth_q - DPW'(1);
        b_d     = stk_dout;
        state_d = WB;
      end
      PEEK: begin
        stk_tos = 1'b1;
        state_d = op_q == OP_TOS ? OUT : WB;
      end
      WB: begin
        stk_push = 1'b1;
        stk_din  = alu;
        depth_d  = depth_q + DPW'(1);
        state_d  = IDLE;
      end
      OUT: begin
        result_d = stk_dout;
        rv_d     = 1'b1;
        state_d  = IDLE;
      end
      ERR: begin
        error   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_PUSH;
      imm_q    <= '0;
      b_q      <= '0;
      result_q <= '0;
      depth_q  <= '0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      imm_q    <= imm_d;
      b_q      <= b_d;
      result_q <= result_d;
      depth_q  <= depth_d;
      rv_q     <= rv_d;
    end
  end
  assign cmd_ready    = state_q == IDLE;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign depth        = depth_q;
endmodule

// File: tb/tb_stack_op_sequencer.sv
// tb_stack_op_sequencer: directed and randomized checks of stack_op_sequencer against a queue-based stack model
module tb_stack_op_sequencer;
  logic       clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0;
  logic [2:0] cmd_op = '0;
  logic [7:0] cmd_data = '0;
  logic       cmd_ready, stk_push, stk_pop, stk_tos, result_valid, error;
  logic [7:0] stk_din, stk_dout, result;
  logic [5:0] depth;
  int n_cmp = 0, n_fail = 0, n_acc = 0;
  // observations of the most recent command
  int o_ret, o_np, o_npop, o_ntos, o_nerr;
  bit o_err, o_rv, o_multi;
  logic [7:0] o_res, o_din;
  // behavioural stack attached to the sequencer (registered d_out)
  logic [7:0] mem [32];
  int sp;
  always #5 clk = ~clk;
  stack_op_sequencer #(.DW(8), .DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_tos(stk_tos), .stk_din(stk_din), .stk_dout(stk_dout), .result(result),
    .result_valid(result_valid), .error(error), .depth(depth));
  // the stack model is cleared on reset so later tests start in sync
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= 0;
      stk_dout <= '0;
    end else if (stk_push) begin
      if (sp < 32) mem[sp] <= stk_din;
      sp <= sp + 1;
    end else if (stk_pop) begin
      if (sp > 0) stk_dout <= mem[sp-1];
      sp <= sp - 1;
    end else if (stk_tos) begin
      if (sp > 0) stk_dout <= mem[sp-1];
    end
  end
  always @(posedge clk) if (rst_n && cmd_valid && cmd_ready) n_acc <= n_acc + 1;
  task automatic apply_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  // issue one command at a negedge and observe it until cmd_ready returns
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] d);
    int k;
    o_ret = 0; o_np = 0; o_npop = 0; o_ntos = 0; o_nerr = 0;
    o_err = 0; o_rv = 0; o_multi = 0; o_res = '0; o_din = '0;
    k = 0;
    while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_data = 8'($urandom);
    for (k = 1; k <= 20; k++) begin
      if (stk_push) begin o_np++; o_din = stk_din; end
      if (stk_pop) o_npop++;
      if (stk_tos) o_ntos++;
      if (int'(stk_push) + int'(stk_pop) + int'(stk_tos) > 1) o_multi = 1;
      if (error) begin o_err = 1; o_nerr++; end
      if (result_valid) begin o_rv = 1; o_res = result; end
      if (cmd_ready) begin o_ret = k; break; end
      @(negedge clk);
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++; if ({stk_push, stk_pop, stk_tos, result_valid, error} !== 5'b0) begin n_fail++; $display("FAIL reset_strobes: got %b want 00000", {stk_push, stk_pop, stk_tos, result_valid, error}); end
    apply_reset();
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    n_cmp++; if (depth !== 6'd0) begin n_fail++; $display("FAIL reset_depth: got %0d want 0", depth); end
    n_cmp++; if (result !== 8'h00) begin n_fail++; $display("FAIL reset_result: got %h want 00", result); end
  endtask
  task automatic test_add_pop();
    run_cmd(3'd0, 8'h05);
    n_cmp++; if (depth !== 6'd1 || o_np != 1 || o_ret != 2) begin n_fail++; $display("FAIL push1: depth %0d pushes %0d ret %0d want 1 1 2", depth, o_np, o_ret); end
    run_cmd(3'd0, 8'h03);
    n_cmp++; if (depth !== 6'd2) begin n_fail++; $display("FAIL push2_depth: got %0d want 2", depth); end
    run_cmd(3'd1, 8'h00);
    n_cmp++; if (o_din !== 8'h08 || o_npop != 2 || o_np != 1 || o_ret != 4) begin n_fail++; $display("FAIL add: din %h pops %0d pushes %0d ret %0d want 08 2 1 4", o_din, o_npop, o_np, o_ret); end
    n_cmp++; if (depth !== 6'd1) begin n_fail++; $display("FAIL add_depth: got %0d want 1", depth); end
    run_cmd(3'd5, 8'h00);
    n_cmp++; if (o_rv !== 1'b1 || o_res !== 8'h08 || o_ret != 3) begin n_fail++; $display("FAIL pop: rv %b res %h ret %0d want 1 08 3", o_rv, o_res, o_ret); end
    n_cmp++; if (depth !== 6'd0) begin n_fail++; $display("FAIL pop_depth: got %0d want 0", depth); end
  endtask
  task automatic test_sub_tos();
    run_cmd(3'd0, 8'h03);
    run_cmd(3'd0, 8'h05);
    run_cmd(3'd2, 8'h00);
    n_cmp++; if (o_din !== 8'hFE) begin n_fail++; $display("FAIL sub_din: got %h want fe", o_din); end
    run_cmd(3'd6, 8'h00);
    n_cmp++; if (o_rv !== 1'b1 || o_res !== 8'hFE || o_ntos != 1 || o_npop != 0) begin n_fail++; $display("FAIL tos: rv %b res %h tos %0d pops %0d want 1 fe 1 0", o_rv, o_res, o_ntos, o_npop); end
    n_cmp++; if (depth !== 6'd1) begin n_fail++; $display("FAIL tos_depth: got %0d want 1", depth); end
    run_cmd(3'd5, 8'h00);
  endtask
  task automatic test_not_dup_and();
    run_cmd(3'd0, 8'hF0);
    run_cmd(3'd4, 8'h00);
    n_cmp++; if (o_din !== 8'h0F || o_ret != 3 || depth !== 6'd1) begin n_fail++; $display("FAIL not: din %h ret %0d depth %0d want 0f 3 1", o_din, o_ret, depth); end
    run_cmd(3'd7, 8'h00);
    n_cmp++; if (o_din !== 8'h0F || o_ret != 3 || depth !== 6'd2) begin n_fail++; $display("FAIL dup: din %h ret %0d depth %0d want 0f 3 2", o_din, o_ret, depth); end
    run_cmd(3'd3, 8'h00);
    n_cmp++; if (o_din !== 8'h0F) begin n_fail++; $display("FAIL and_din: got %h want 0f", o_din); end
    run_cmd(3'd5, 8'h00);
    n_cmp++; if (o_res !== 8'h0F || depth !== 6'd0) begin n_fail++; $display("FAIL and_pop: res %h depth %0d want 0f 0", o_res, depth); end
  endtask
  task automatic test_underflow();
    run_cmd(3'd5, 8'h00);
    n_cmp++; if (o_nerr != 1 || o_rv || o_npop != 0 || depth !== 6'd0) begin n_fail++; $display("FAIL pop_empty: errs %0d rv %b pops %0d depth %0d want 1 0 0 0", o_nerr, o_rv, o_npop, depth); end
    run_cmd(3'd0, 8'h11);
    run_cmd(3'd1, 8'h00);
    n_cmp++; if (o_nerr != 1 || o_np != 0 || o_npop != 0 || o_ret != 2) begin n_fail++; $display("FAIL add_underflow: errs %0d pushes %0d pops %0d ret %0d want 1 0 0 2", o_nerr, o_np, o_npop, o_ret); end
    n_cmp++; if (depth !== 6'd1) begin n_fail++; $display("FAIL underflow_depth: got %0d want 1", depth); end
    run_cmd(3'd5, 8'h00);
    n_cmp++; if (o_res !== 8'h11) begin n_fail++; $display("FAIL underflow_pop: got %h want 11", o_res); end
  endtask
  task automatic test_overflow();
    for (int i = 0; i < 32; i++) run_cmd(3'd0, 8'(i));
    n_cmp++; if (depth !== 6'd32) begin n_fail++; $display("FAIL full_depth: got %0d want 32", depth); end
    run_cmd(3'd0, 8'hAA);
    n_cmp++; if (o_nerr != 1 || o_np != 0 || depth !== 6'd32) begin n_fail++; $display("FAIL push_full: errs %0d pushes %0d depth %0d want 1 0 32", o_nerr, o_np, depth); end
    run_cmd(3'd7, 8'h00);
    n_cmp++; if (o_nerr != 1 || o_ntos != 0) begin n_fail++; $display("FAIL dup_full: errs %0d tos %0d want 1 0", o_nerr, o_ntos); end
    run_cmd(3'd1, 8'h00);
    n_cmp++; if (o_err || o_din !== 8'h3D || depth !== 6'd31) begin n_fail++; $display("FAIL add_full: err %b din %h depth %0d want 0 3d 31", o_err, o_din, depth); end
    run_cmd(3'd5, 8'h00);
    n_cmp++; if (o_res !== 8'h3D || depth !== 6'd30) begin n_fail++; $display("FAIL pop_full: res %h depth %0d want 3d 30", o_res, depth); end
    apply_reset();
  endtask
  task automatic test_handshake_reset();
    int acc0, k;
    run_cmd(3'd0, 8'h01);
    run_cmd(3'd0, 8'h02);
    acc0 = n_acc;
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = 8'h00;
    @(negedge clk);
    k = 0;
    while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
    cmd_valid = 1'b0;
    n_cmp++; if (n_acc - acc0 != 1 || depth !== 6'd1) begin n_fail++; $display("FAIL held_valid: accepts %0d depth %0d want 1 1", n_acc - acc0, depth); end
    n_cmp++; if (sp != 1 || mem[0] !== 8'h03) begin n_fail++; $display("FAIL held_stack: sp %0d top %h want 1 03", sp, mem[0]); end
    run_cmd(3'd0, 8'h04);
    cmd_valid = 1'b1; cmd_op = 3'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (stk_pop !== 1'b1 || depth !== 6'd1) begin n_fail++; $display("FAIL rda_state: pop %b depth %0d want 1 1", stk_pop, depth); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({stk_push, stk_pop, stk_tos, error} !== 4'b0 || depth !== 6'd0) begin n_fail++; $display("FAIL midop_reset: strobes %b depth %0d want 0000 0", {stk_push, stk_pop, stk_tos, error}, depth); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1 || depth !== 6'd0 || result_valid !== 1'b0) begin n_fail++; $display("FAIL after_reset: ready %b depth %0d rv %b want 1 0 0", cmd_ready, depth, result_valid); end
  endtask
  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] a, b, e_res, e_din;
    logic [2:0] op;
    int need, e_ret, r;
    bit e_err, e_rv, e_push, same;
    apply_reset();
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      op = r < 3 ? 3'd0 : 3'(r - 2);
      a = 8'($urandom);
      need = op == 3'd0 ? 0 : (op inside {3'd1, 3'd2, 3'd3}) ? 2 : 1;
      e_err = q.size() < need || ((op == 3'd0 || op == 3'd7) && q.size() == 32);
      e_rv = 0; e_push = 0; e_res = '0; e_din = '0;
      if (!e_err) begin
        case (op)
          3'd0: e_din = a;
          3'd1: begin b = q.pop_back(); e_din = q.pop_back() + b; end
          3'd2: begin b = q.pop_back(); e_din = q.pop_back() - b; end
          3'd3: begin b = q.pop_back(); e_din = q.pop_back() & b; end
          3'd4: e_din = ~q.pop_back();
          3'd5: begin e_res = q.pop_back(); e_rv = 1; end
          3'd6: begin e_res = q[$]; e_rv = 1; end
          default: e_din = q[$];
        endcase
        e_push = !(op inside {3'd5, 3'd6});
        if (e_push) q.push_back(e_din);
      end
      e_ret = e_err || op == 3'd0 ? 2 : (op inside {3'd1, 3'd2, 3'd3}) ? 4 : 3;
      run_cmd(op, a);
      n_cmp++; if (o_err !== e_err || o_nerr > 1 || o_ret != e_ret || o_multi) begin n_fail++; $display("FAIL rnd_ctl[%0d] op %0d: err %b ret %0d multi %b want %b %0d 0", n, op, o_err, o_ret, o_multi, e_err, e_ret); end
      n_cmp++; if (o_rv !== e_rv || (e_rv && o_res !== e_res)) begin n_fail++; $display("FAIL rnd_result[%0d] op %0d: rv %b res %h want %b %h", n, op, o_rv, o_res, e_rv, e_res); end
      n_cmp++; if ((o_np == 1) !== e_push || (e_push && o_din !== e_din)) begin n_fail++; $display("FAIL rnd_din[%0d] op %0d: pushes %0d din %h want %b %h", n, op, o_np, o_din, e_push, e_din); end
      same = sp == q.size();
      for (int i = 0; i < q.size() && i < 32; i++) if (mem[i] !== q[i]) same = 0;
      n_cmp++; if (int'(depth) != q.size() || !same) begin n_fail++; $display("FAIL rnd_stack[%0d] op %0d: depth %0d sp %0d want %0d", n, op, depth, sp, q.size()); end
    end
  endtask
  initial begin
    test_reset();
    test_add_pop();
    test_sub_tos();
    test_not_dup_and();
    test_underflow();
    test_overflow();
    test_handshake_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
